w_stage_wb: RTL and testbench



---
 rtl/w_stage_wb.sv | 111 +++++++++++
 tb/tb_w_stage_wb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/w_stage_wb.sv
// w_stage_wb: M/W pipeline register, writeback data select/format, GRF write port and retire counter.
// Define W_LOAD_EXT_EN to enable byte/half load extraction and extension on source 01.
module w_stage_wb #(
  parameter int DW = 32,
  parameter int LINK_OFF = 4,
  parameter logic [DW-1:0] PC_RST = 32'h0000_3000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_stall,
  input  logic             w_flush,
  input  logic             m_valid,
  input  logic [DW-1:0]    m_ans,
  input  logic [DW-1:0]    m_rdata,
  input  logic [DW-1:0]    m_pc,
  input  logic [DW-1:0]    m_aux,
  input  logic [1:0]       m_sel,
  input  logic             m_we,
  input  logic [4:0]       m_waddr,
  input  logic [2:0]       m_ld_type,
  input  logic [1:0]       m_byte_off,
  output logic             w_valid,
  output logic             w_we,
  output logic [4:0]       w_waddr,
  output logic [DW-1:0]    w_wdata,
  output logic [DW-1:0]    w_pc,
  output logic [CNT_W-1:0] w_retire_cnt
);
  logic             reg_valid, reg_we;
  logic [4:0]       reg_waddr;
  logic [DW-1:0]    reg_ans, reg_rdata, reg_pc, reg_aux, ld_data;
  logic [1:0]       reg_sel;
  logic [CNT_W-1:0] cnt;
  logic             load, retire;

  assign load   = !w_flush && !w_stall;
  // An instruction leaves W whenever it is displaced: by a new load or by a flush.
  assign retire = reg_valid && (w_flush || !w_stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_valid <= 1'b0;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_ans   <= '0;
      reg_rdata <= '0;
      reg_pc    <= PC_RST;
      reg_aux   <= '0;
      reg_sel   <= 2'b00;
      cnt       <= '0;
    end else begin
      if (w_flush) begin
        reg_valid <= 1'b0;
        reg_we    <= 1'b0;
        reg_waddr <= '0;
      end else if (load) begin
        reg_valid <= m_valid;
        reg_we    <= m_we;
        reg_waddr <= m_waddr;
        reg_ans   <= m_ans;
        reg_rdata <= m_rdata;
        reg_pc    <= m_pc;
        reg_aux   <= m_aux;
        reg_sel   <= m_sel;
      end
      if (retire) cnt <= cnt + 1'b1;
    end
  end

`ifdef W_LOAD_EXT_EN
  logic [2:0]  reg_ld_type;
  logic [1:0]  reg_off;
  logic [7:0]  lb;
  logic [15:0] lh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_ld_type <= '0;
      reg_off     <= '0;
    end else if (load) begin
      reg_ld_type <= m_ld_type;
      reg_off     <= m_byte_off;
    end
  end

  always_comb begin
    lb = 8'(reg_rdata >> {reg_off, 3'b000});
    lh = 16'(reg_rdata >> {reg_off[1], 4'b0000});
    ld_data = (reg_ld_type == 3'd1) ? {{(DW-8){1'b0}}, lb} :
              (reg_ld_type == 3'd2) ? {{(DW-8){lb[7]}}, lb} :
              (reg_ld_type == 3'd3) ? {{(DW-16){1'b0}}, lh} :
              (reg_ld_type == 3'd4) ? {{(DW-16){lh[15]}}, lh} : reg_rdata;
  end
`else
  logic unused_ld;
  assign unused_ld = ^{m_ld_type, m_byte_off};
  assign ld_data = reg_rdata;
`endif

  always_comb begin
    w_valid      = reg_valid;
    w_we         = reg_we && reg_valid && (reg_waddr != 5'd0);
    w_waddr      = w_we ? reg_waddr : 5'd0;
    w_pc         = reg_pc;
    w_retire_cnt = cnt;
    w_wdata      = (reg_sel == 2'b00) ? reg_ans :
                   (reg_sel == 2'b01) ? ld_data :
                   (reg_sel == 2'b10) ? reg_pc + DW'(LINK_OFF) : reg_aux;
  end
endmodule

// File: tb/tb_w_stage_wb.sv
// tb_w_stage_wb: table vectors, hand sequences and random stimulus against a behavioural model.
module tb_w_stage_wb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        w_stall, w_flush, m_valid, m_we;
  logic [31:0] m_ans, m_rdata, m_pc, m_aux;
  logic [1:0]  m_sel, m_byte_off;
  logic [4:0]  m_waddr;
  logic [2:0]  m_ld_type;
  logic        w_valid, w_we, v4, we4;
  logic [4:0]  w_waddr, wa4;
  logic [31:0] w_wdata, w_pc, w_retire_cnt, wd4, pc4;
  logic [3:0]  cnt4;

  int checks = 0, errors = 0;

  logic        mv, mwe;
  logic [4:0]  mwaddr;
  logic [31:0] mans, mrdata, mpc, maux, mcnt;
  logic [1:0]  msel, moff;
  logic [2:0]  mlt;

  typedef struct {
    logic flush, stall, valid, we;
    logic [4:0] waddr;
    logic [31:0] ans, rdata, pc, aux;
    logic [1:0] sel;
    logic [2:0] lt;
    logic [1:0] off;
    logic [31:0] exp_ext, exp_raw;
    logic exp_we;
  } vec_t;
  vec_t tbl[$];

  w_stage_wb dut (.clk(clk), .rst_n(rst_n), .w_stall(w_stall), .w_flush(w_flush), .m_valid(m_valid),
    .m_ans(m_ans), .m_rdata(m_rdata), .m_pc(m_pc), .m_aux(m_aux), .m_sel(m_sel), .m_we(m_we),
    .m_waddr(m_waddr), .m_ld_type(m_ld_type), .m_byte_off(m_byte_off), .w_valid(w_valid), .w_we(w_we),
    .w_waddr(w_waddr), .w_wdata(w_wdata), .w_pc(w_pc), .w_retire_cnt(w_retire_cnt));

  w_stage_wb #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .w_stall(w_stall), .w_flush(w_flush),
    .m_valid(m_valid), .m_ans(m_ans), .m_rdata(m_rdata), .m_pc(m_pc), .m_aux(m_aux), .m_sel(m_sel),
    .m_we(m_we), .m_waddr(m_waddr), .m_ld_type(m_ld_type), .m_byte_off(m_byte_off), .w_valid(v4),
    .w_we(we4), .w_waddr(wa4), .w_wdata(wd4), .w_pc(pc4), .w_retire_cnt(cnt4));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] rd, input logic [2:0] lt, input logic [1:0] off);
`ifdef W_LOAD_EXT_EN
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * off[1])) & 32'hFFFF;
    case (lt)
      3'd1: return b;
      3'd2: return (b >= 128) ? b - 256 : b;
      3'd3: return h;
      3'd4: return (h >= 32768) ? h - 65536 : h;
      default: return rd;
    endcase
`else
    return rd;
`endif
  endfunction

  function automatic logic [31:0] exp_wdata();
    case (msel)
      2'd0: return mans;
      2'd1: return fmt(mrdata, mlt, moff);
      2'd2: return mpc + 4;
      default: return maux;
    endcase
  endfunction

  task automatic model_reset();
    mv = 0; mwe = 0; mwaddr = 0; mans = 0; mrdata = 0; mpc = 32'h3000; maux = 0;
    msel = 0; mlt = 0; moff = 0; mcnt = 0;
  endtask

  task automatic model_edge();
    if (mv && (w_flush || !w_stall)) mcnt++;
    if (w_flush) begin
      mv = 0; mwe = 0; mwaddr = 0;
    end else if (!w_stall) begin
      mv = m_valid; mwe = m_we; mwaddr = m_waddr; mans = m_ans; mrdata = m_rdata;
      mpc = m_pc; maux = m_aux; msel = m_sel; mlt = m_ld_type; moff = m_byte_off;
    end
  endtask

  task automatic check_all();
    logic ewe;
    ewe = mwe && mv && (mwaddr != 0);
    check("valid", 32'(w_valid), 32'(mv));
    check("we", 32'(w_we), 32'(ewe));
    check("waddr", 32'(w_waddr), ewe ? 32'(mwaddr) : 0);
    check("wdata", w_wdata, exp_wdata());
    check("pc", w_pc, mpc);
    check("cnt", w_retire_cnt, mcnt);
    check("cnt4", 32'(cnt4), mcnt & 32'hF);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input vec_t v);
    w_flush = v.flush; w_stall = v.stall; m_valid = v.valid; m_we = v.we; m_waddr = v.waddr;
    m_ans = v.ans; m_rdata = v.rdata; m_pc = v.pc; m_aux = v.aux; m_sel = v.sel;
    m_ld_type = v.lt; m_byte_off = v.off;
  endtask

  task automatic pulse_reset();
    #3 rst_n = 0;
    #1;
    model_reset();
    check("rst_valid", 32'(w_valid), 0);
    check("rst_we", 32'(w_we), 0);
    check("rst_wdata", w_wdata, 0);
    check("rst_pc", w_pc, 32'h3000);
    check("rst_cnt", w_retire_cnt, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    vec_t v;
    logic [31:0] snap_d, snap_c;
    w_stall = 0; w_flush = 0; m_valid = 0; m_we = 0; m_ans = 0; m_rdata = 0; m_pc = 0; m_aux = 0;
    m_sel = 0; m_waddr = 0; m_ld_type = 0; m_byte_off = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;

    tbl.push_back('{0,0,1,1,5'd5, 32'h1234_5678,0,0,0, 2'd0,3'd0,2'd0, 32'h1234_5678,32'h1234_5678,1});
    tbl.push_back('{0,0,1,1,5'd6, 0,0,32'h3010,0, 2'd2,3'd0,2'd0, 32'h0000_3014,32'h0000_3014,1});
    tbl.push_back('{0,0,1,1,5'd7, 0,0,0,32'hDEAD_BEEF, 2'd3,3'd0,2'd0, 32'hDEAD_BEEF,32'hDEAD_BEEF,1});
    tbl.push_back('{0,0,1,1,5'd8, 0,32'h80FF_7F01,0,0, 2'd1,3'd2,2'd3, 32'hFFFF_FF80,32'h80FF_7F01,1});
    tbl.push_back('{0,0,1,1,5'd8, 0,32'h80FF_7F01,0,0, 2'd1,3'd1,2'd3, 32'h0000_0080,32'h80FF_7F01,1});
    tbl.push_back('{0,0,1,1,5'd8, 0,32'h80FF_7F01,0,0, 2'd1,3'd4,2'd2, 32'hFFFF_80FF,32'h80FF_7F01,1});
    tbl.push_back('{0,0,1,1,5'd8, 0,32'h80FF_7F01,0,0, 2'd1,3'd3,2'd0, 32'h0000_7F01,32'h80FF_7F01,1});
    tbl.push_back('{0,0,1,1,5'd8, 0,32'h80FF_7F01,0,0, 2'd1,3'd0,2'd1, 32'h80FF_7F01,32'h80FF_7F01,1});
    tbl.push_back('{0,0,1,1,5'd8, 0,32'h80FF_7F01,0,0, 2'd1,3'd7,2'd2, 32'h80FF_7F01,32'h80FF_7F01,1});
    tbl.push_back('{0,0,1,1,5'd0, 32'h1,0,0,0, 2'd0,3'd0,2'd0, 32'h1,32'h1,0});
    tbl.push_back('{0,0,1,1,5'd31, 32'h2,0,0,0, 2'd0,3'd0,2'd0, 32'h2,32'h2,1});
    tbl.push_back('{0,0,0,1,5'd3, 32'h3,0,0,0, 2'd0,3'd0,2'd0, 32'h3,32'h3,0});
    foreach (tbl[i]) begin
      drive(tbl[i]);
      step();
`ifdef W_LOAD_EXT_EN
      check($sformatf("tbl%0d_wdata", i), w_wdata, tbl[i].exp_ext);
`else
      check($sformatf("tbl%0d_wdata", i), w_wdata, tbl[i].exp_raw);
`endif
      check($sformatf("tbl%0d_we", i), 32'(w_we), 32'(tbl[i].exp_we));
      check($sformatf("tbl%0d_waddr", i), 32'(w_waddr), tbl[i].exp_we ? 32'(tbl[i].waddr) : 0);
    end

    pulse_reset();

    v = '{0,0,1,1,5'd7, 32'hAAAA_5555,0,0,0, 2'd0,3'd0,2'd0, 0,0,1};
    drive(v);
    step();
    snap_d = w_wdata; snap_c = w_retire_cnt;
    w_stall = 1;
    for (int k = 0; k < 3; k++) begin
      m_ans = $urandom; m_valid = 1; m_waddr = 5'd9;
      step();
      check("stall_wdata", w_wdata, snap_d);
      check("stall_cnt", w_retire_cnt, snap_c);
      check("stall_valid", 32'(w_valid), 1);
    end
    w_flush = 1;
    step();
    check("flush_valid", 32'(w_valid), 0);
    check("flush_we", 32'(w_we), 0);
    check("flush_cnt", w_retire_cnt, snap_c + 1);
    w_flush = 0; w_stall = 0;

    pulse_reset();
    v = '{0,0,1,1,5'd4, 32'h5,0,0,0, 2'd0,3'd0,2'd0, 0,0,1};
    drive(v);
    repeat (17) step();
    check("wrap_cnt4", 32'(cnt4), 0);
    check("wrap_cnt", w_retire_cnt, 16);

    for (int k = 0; k < 400; k++) begin
      w_flush = ($urandom_range(0, 7) == 0);
      w_stall = ($urandom_range(0, 3) == 0);
      m_valid = $urandom; m_we = $urandom; m_waddr = 5'($urandom);
      m_ans = $urandom; m_rdata = $urandom; m_pc = $urandom; m_aux = $urandom;
      m_sel = 2'($urandom); m_ld_type = 3'($urandom); m_byte_off = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
